uart_cmd_decoder: RTL and testbench

- Consumes the byte stream popped from the UART RX FIFO (`Rx_trigger` / `Rx_fifo_data`).
- Assembles bytes into short ASCII command lines and decodes each completed line into a one-cycle command strobe for the stopwatch, DHT11 and SR04 controllers.
- Sits directly downstream of the UART top, in parallel with its echo path.
- Has no backpressure: every strobed byte is consumed.

---
 rtl/uart_cmd_pkg.sv | 41 ++++
 rtl/uart_cmd_match.sv | 41 ++++
 rtl/uart_cmd_decoder.sv | 129 ++++++++++++
 tb/tb_uart_cmd_decoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command decoder: command codes, ASCII control
// characters, keyword table entries and the collector FSM state type.
package uart_cmd_pkg;

   localparam logic [2:0] CMD_NONE = 3'd0;
   localparam logic [2:0] CMD_RUN  = 3'd1;
   localparam logic [2:0] CMD_CLR  = 3'd2;
   localparam logic [2:0] CMD_MODE = 3'd3;
   localparam logic [2:0] CMD_DHT  = 3'd4;
   localparam logic [2:0] CMD_SR   = 3'd5;
   localparam logic [2:0] CMD_ERR  = 3'd7;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_BS = 8'h08;

   localparam int DEFAULT_MAX_LEN = 4;

   // Keywords are stored first character in the low byte, unused bytes zero.
   localparam logic [31:0] KW_RUN  = 32'h004E5552;
   localparam logic [31:0] KW_CLR  = 32'h00524C43;
   localparam logic [31:0] KW_MODE = 32'h45444F4D;
   localparam logic [31:0] KW_DHT  = 32'h00544844;
   localparam logic [31:0] KW_SR   = 32'h00005253;

   localparam int LEN_RUN  = 3;
   localparam int LEN_CLR  = 3;
   localparam int LEN_MODE = 4;
   localparam int LEN_DHT  = 3;
   localparam int LEN_SR   = 2;

   typedef enum logic {
      ST_COLLECT,
      ST_DISCARD
   } state_t;

   function automatic logic [7:0] fold_case(input logic [7:0] c);
      return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
   endfunction

endpackage

// File: rtl/uart_cmd_match.sv
// Combinational keyword lookup: maps the collected line buffer and its length
// to a command code, CMD_NONE when nothing matches exactly.
module uart_cmd_match
   import uart_cmd_pkg::*;
#(
   parameter int MAX_LEN = DEFAULT_MAX_LEN,
   localparam int CW = $clog2(MAX_LEN + 1)
) (
   input  logic [8*MAX_LEN-1:0] line_buf,
   input  logic [CW-1:0]        count,
   output logic [2:0]           code
);

   localparam int NCMP = (MAX_LEN < 4) ? MAX_LEN : 4;

   logic [31:0] view;

   // Bytes past the current length may be stale, so they are zeroed before
   // comparing; together with the length check this makes the match exact.
   always_comb begin
      view = '0;
      for (int i = 0; i < NCMP; i++) begin
         if (i < int'(count)) begin
            view[8*i +: 8] = line_buf[8*i +: 8];
         end
      end
      code = CMD_NONE;
      if (int'(count) == LEN_RUN && view == KW_RUN) begin
         code = CMD_RUN;
      end else if (int'(count) == LEN_CLR && view == KW_CLR) begin
         code = CMD_CLR;
      end else if (int'(count) == LEN_MODE && view == KW_MODE) begin
         code = CMD_MODE;
      end else if (int'(count) == LEN_DHT && view == KW_DHT) begin
         code = CMD_DHT;
      end else if (int'(count) == LEN_SR && view == KW_SR) begin
         code = CMD_SR;
      end
   end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles bytes popped from the UART RX FIFO into short ASCII lines and
// turns each completed line into a one-cycle command strobe.
module uart_cmd_decoder
   import uart_cmd_pkg::*;
#(
   parameter int MAX_LEN        = DEFAULT_MAX_LEN,
   parameter int TIMEOUT_CYCLES = 100_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_trigger,
   input  logic [7:0] rx_data,
   output logic       cmd_valid,
   output logic [2:0] cmd_code,
   output logic       cmd_run,
   output logic       cmd_clr,
   output logic       cmd_mode,
   output logic       cmd_dht,
   output logic       cmd_sr,
   output logic       cmd_err
);

   localparam int CW = $clog2(MAX_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

   state_t              state;
   state_t              eff_state;
   logic [CW-1:0]       count;
   logic [CW-1:0]       eff_count;
   logic [8*MAX_LEN-1:0] line_buf;
   logic [TW-1:0]       tmo_cnt;
   logic [7:0]          ch;
   logic                is_term;
   logic                timeout_hit;
   logic [2:0]          match_code;

   assign ch      = fold_case(rx_data);
   assign is_term = (ch == ASCII_CR) || (ch == ASCII_LF);

   // A timeout on the same edge as a new byte must let that byte start a fresh
   // line, so the byte logic works from these post-timeout views.
   assign timeout_hit = (tmo_cnt == TMO_MAX) && ((count != '0) || (state == ST_DISCARD));
   assign eff_count   = timeout_hit ? '0 : count;
   assign eff_state   = timeout_hit ? ST_COLLECT : state;

   uart_cmd_match #(
      .MAX_LEN (MAX_LEN)
   ) u_match (
      .line_buf (line_buf),
      .count    (count),
      .code     (match_code)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_COLLECT;
         count     <= '0;
         line_buf  <= '0;
         tmo_cnt   <= '0;
         cmd_valid <= 1'b0;
         cmd_code  <= CMD_NONE;
         cmd_run   <= 1'b0;
         cmd_clr   <= 1'b0;
         cmd_mode  <= 1'b0;
         cmd_dht   <= 1'b0;
         cmd_sr    <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         cmd_valid <= 1'b0;
         cmd_run   <= 1'b0;
         cmd_clr   <= 1'b0;
         cmd_mode  <= 1'b0;
         cmd_dht   <= 1'b0;
         cmd_sr    <= 1'b0;
         cmd_err   <= 1'b0;

         if (rx_trigger) begin
            tmo_cnt <= '0;
         end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end

         if (timeout_hit) begin
            count <= '0;
            state <= ST_COLLECT;
         end

         if (rx_trigger) begin
            if (eff_state == ST_COLLECT) begin
               if (is_term) begin
                  // Empty lines are swallowed so CRLF pairs stay silent.
                  if (eff_count != '0) begin
                     count <= '0;
                     if (match_code != CMD_NONE) begin
                        cmd_valid <= 1'b1;
                        cmd_code  <= match_code;
                        cmd_run   <= (match_code == CMD_RUN);
                        cmd_clr   <= (match_code == CMD_CLR);
                        cmd_mode  <= (match_code == CMD_MODE);
                        cmd_dht   <= (match_code == CMD_DHT);
                        cmd_sr    <= (match_code == CMD_SR);
                     end else begin
                        cmd_err  <= 1'b1;
                        cmd_code <= CMD_ERR;
                     end
                  end
               end else if (ch == ASCII_BS) begin
                  if (eff_count != '0) begin
                     count <= eff_count - CW'(1);
                  end
               end else if (eff_count < MAX_CNT) begin
                  line_buf[{eff_count, 3'b000} +: 8] <= ch;
                  count <= eff_count + CW'(1);
               end else begin
                  state <= ST_DISCARD;
                  count <= '0;
               end
            end else if (is_term) begin
               cmd_err  <= 1'b1;
               cmd_code <= CMD_ERR;
               state    <= ST_COLLECT;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder with a short timeout so idle-line
// expiry can be exercised in a few dozen cycles.
module tb_uart_cmd_decoder;

   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] LF = 8'h0A;
   localparam logic [7:0] BS = 8'h08;

   logic       clk;
   logic       rst;
   logic       rx_trigger;
   logic [7:0] rx_data;
   logic       cmd_valid;
   logic [2:0] cmd_code;
   logic       cmd_run;
   logic       cmd_clr;
   logic       cmd_mode;
   logic       cmd_dht;
   logic       cmd_sr;
   logic       cmd_err;

   int vectors     = 0;
   int miscompares = 0;

   int n_run   = 0;
   int n_clr   = 0;
   int n_mode  = 0;
   int n_dht   = 0;
   int n_sr    = 0;
   int n_err   = 0;
   int n_valid = 0;
   int n_multi = 0;

   uart_cmd_decoder #(
      .MAX_LEN        (4),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_trigger (rx_trigger),
      .rx_data    (rx_data),
      .cmd_valid  (cmd_valid),
      .cmd_code   (cmd_code),
      .cmd_run    (cmd_run),
      .cmd_clr    (cmd_clr),
      .cmd_mode   (cmd_mode),
      .cmd_dht    (cmd_dht),
      .cmd_sr     (cmd_sr),
      .cmd_err    (cmd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tally every strobe seen while out of reset and flag any overlap.
   always @(negedge clk) begin
      if (rst) begin
         n_run   <= n_run + int'(cmd_run);
         n_clr   <= n_clr + int'(cmd_clr);
         n_mode  <= n_mode + int'(cmd_mode);
         n_dht   <= n_dht + int'(cmd_dht);
         n_sr    <= n_sr + int'(cmd_sr);
         n_err   <= n_err + int'(cmd_err);
         n_valid <= n_valid + int'(cmd_valid);
         if ((int'(cmd_run) + int'(cmd_clr) + int'(cmd_mode) + int'(cmd_dht)
              + int'(cmd_sr) + int'(cmd_err)) > 1) begin
            n_multi <= n_multi + 1;
         end
      end
   end

   // Called at a negedge; the byte is taken on the next posedge and the
   // task returns at the following negedge, where its effect is visible.
   task automatic applyStimulus(input logic [7:0] b);
      rx_trigger = 1'b1;
      rx_data    = b;
      @(negedge clk);
      rx_trigger = 1'b0;
   endtask

   task automatic sendString(input string s);
      for (int i = 0; i < s.len(); i++) begin
         applyStimulus(s[i]);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic exp_valid,
                              input logic [2:0] exp_code, input logic [5:0] exp_str);
      logic [5:0] str;
      str = {cmd_run, cmd_clr, cmd_mode, cmd_dht, cmd_sr, cmd_err};
      vectors++;
      assert (cmd_valid === exp_valid) else begin
         miscompares++;
         $error("[TB] FAIL %s cmd_valid: got %b expected %b", tag, cmd_valid, exp_valid);
      end
      vectors++;
      assert (cmd_code === exp_code) else begin
         miscompares++;
         $error("[TB] FAIL %s cmd_code: got %0d expected %0d", tag, cmd_code, exp_code);
      end
      vectors++;
      assert (str === exp_str) else begin
         miscompares++;
         $error("[TB] FAIL %s strobes run/clr/mode/dht/sr/err: got %b expected %b",
                tag, str, exp_str);
      end
   endtask

   task automatic checkCount(input string tag, input int got, input int exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   initial begin
      rst        = 1'b0;
      rx_trigger = 1'b0;
      rx_data    = 8'h00;
      idle(3);
      checkOutput("reset", 1'b0, 3'd0, 6'b000000);
      rst = 1'b1;
      idle(2);

      // Lower-case "run" with gaps, then CRLF.
      applyStimulus("r"); idle(3);
      applyStimulus("u"); idle(3);
      applyStimulus("n"); idle(3);
      checkOutput("run_pre_cr", 1'b0, 3'd0, 6'b000000);
      applyStimulus(CR);
      checkOutput("run_cr", 1'b1, 3'd1, 6'b100000);
      idle(3);
      applyStimulus(LF);
      checkOutput("run_lf", 1'b0, 3'd1, 6'b000000);

      // Back-to-back "MODE\n" and "SR\n".
      sendString("MODE");
      applyStimulus(LF);
      checkOutput("mode_pulse", 1'b1, 3'd3, 6'b001000);
      applyStimulus("S");
      checkOutput("mode_gap1", 1'b0, 3'd3, 6'b000000);
      applyStimulus("R");
      checkOutput("mode_gap2", 1'b0, 3'd3, 6'b000000);
      applyStimulus(LF);
      checkOutput("sr_pulse", 1'b1, 3'd5, 6'b000010);

      // Overlong line goes to discard, then a good DHT.
      sendString("DHTX");
      applyStimulus("X");
      checkOutput("ovf_drop", 1'b0, 3'd5, 6'b000000);
      applyStimulus(CR);
      checkOutput("ovf_err", 1'b0, 3'd7, 6'b000001);
      sendString("DHT");
      applyStimulus(CR);
      checkOutput("dht_pulse", 1'b1, 3'd4, 6'b000100);

      // Backspace editing, then an unknown word.
      sendString("CLX");
      applyStimulus(BS);
      applyStimulus("R");
      applyStimulus(CR);
      checkOutput("clr_bs", 1'b1, 3'd2, 6'b010000);
      sendString("XYZ");
      applyStimulus(CR);
      checkOutput("xyz_err", 1'b0, 3'd7, 6'b000001);

      // Prefix of a keyword must not match.
      sendString("RU");
      applyStimulus(CR);
      checkOutput("ru_short", 1'b0, 3'd7, 6'b000001);

      // Timeout drops a partial line silently.
      sendString("SR");
      applyStimulus(CR);
      checkOutput("sr_again", 1'b1, 3'd5, 6'b000010);
      sendString("CL");
      idle(60);
      applyStimulus(CR);
      checkOutput("tmo_blank", 1'b0, 3'd5, 6'b000000);
      sendString("CL");
      idle(60);
      applyStimulus("R");
      applyStimulus(CR);
      checkOutput("tmo_r_err", 1'b0, 3'd7, 6'b000001);

      // Reset in the middle of "RUN".
      sendString("RU");
      rst = 1'b0;
      idle(2);
      checkOutput("mid_reset", 1'b0, 3'd0, 6'b000000);
      rst = 1'b1;
      idle(1);
      applyStimulus("N");
      applyStimulus(CR);
      checkOutput("post_reset_n", 1'b0, 3'd7, 6'b000001);
      idle(2);

      checkCount("total_run", n_run, 1);
      checkCount("total_clr", n_clr, 1);
      checkCount("total_mode", n_mode, 1);
      checkCount("total_dht", n_dht, 1);
      checkCount("total_sr", n_sr, 2);
      checkCount("total_err", n_err, 5);
      checkCount("total_valid", n_valid, 6);
      checkCount("strobe_overlap", n_multi, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
